// File: rtl/clock_divider_multi.sv
// -----------------------------------------------------------------------------
// clock_divider_multi
//   Runtime-programmable multi-channel clock divider / tick generator.
//   Each channel divides clk by 2*D, where D is the channel's active
//   half-period, and drives a 50% duty clock-enable waveform plus a
//   one-cycle tick in the cycle the waveform rises. New divisors are written
//   into a shadow register and applied at the channel's next half-period
//   boundary, so the waveform never glitches. A stopped channel (D=0)
//   picks up a new divisor on the next edge.
//
//   Optional feature macro: CLKDIV_PHASE_SYNC_EN
//     defined     : sync=1 restarts every running channel at phase zero
//                   (cnt=0, clk_out=0) and applies pending shadows.
//     not defined : sync is accepted but ignored; no sync logic is built.
//
// Ports
//   clk      in   1       system clock, posedge
//   rst_n    in   1       asynchronous active-low reset
//   wr_en    in   1       divisor write strobe
//   wr_ch    in   CH_W    channel index for the write (>= NUM_CH ignored)
//   wr_div   in   DIV_W   new half-period in clk cycles, 0 stops the channel
//   sync     in   1       phase-align strobe
//   clk_out  out  NUM_CH  divided waveform per channel (registered)
//   tick     out  NUM_CH  one-cycle pulse when clk_out[i] rises (registered)
//   pending  out  NUM_CH  shadow divisor written but not yet applied
// -----------------------------------------------------------------------------
module clock_divider_multi #(
  parameter  int NUM_CH    = 4,
  parameter  int DIV_W     = 16,
  parameter  int DIV_RESET = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam int unsigned      NUM_CH_U  = NUM_CH;
  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

  logic wr_valid_s;
  logic sync_s;

  // Qualify the write strobe: indices beyond the last channel are dropped.
  always_comb begin
    wr_valid_s = 1'b0;
    if (wr_en && (32'(wr_ch) < NUM_CH_U)) begin
      wr_valid_s = 1'b1;
    end else begin
      wr_valid_s = 1'b0;
    end
  end

`ifdef CLKDIV_PHASE_SYNC_EN
  assign sync_s = sync;
`else
  // Port kept for a uniform interface; it has no effect in this build.
  logic sync_unused_s;
  assign sync_unused_s = sync;
  assign sync_s        = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] active_r;
    logic [DIV_W-1:0] shadow_r;
    logic             pending_r;
    logic             clk_out_r;
    logic             tick_r;

    logic [DIV_W-1:0] cnt_nx_s;
    logic [DIV_W-1:0] active_nx_s;
    logic [DIV_W-1:0] shadow_nx_s;
    logic [DIV_W-1:0] next_div_s;
    logic             pending_nx_s;
    logic             clk_out_nx_s;
    logic             tick_nx_s;
    logic             wr_hit_s;
    logic             running_s;
    logic             boundary_s;

    assign wr_hit_s   = wr_valid_s && (wr_ch == CH_W'(i));
    assign running_s  = (active_r != DIV_ZERO);
    // cnt never exceeds active-1, so equality marks the last cycle of a half-period.
    assign boundary_s = running_s && (cnt_r == (active_r - DIV_ONE));

    // Channel next-state: sync, stopped, boundary and mid-period cases.
    always_comb begin
      cnt_nx_s     = cnt_r;
      active_nx_s  = active_r;
      shadow_nx_s  = shadow_r;
      pending_nx_s = pending_r;
      clk_out_nx_s = clk_out_r;
      tick_nx_s    = 1'b0;
      next_div_s   = active_r;

      if (sync_s && running_s) begin
        // Restart at phase zero; a same-cycle write waits as pending.
        cnt_nx_s     = DIV_ZERO;
        clk_out_nx_s = 1'b0;
        if (pending_r) begin
          active_nx_s = shadow_r;
        end else begin
          active_nx_s = active_r;
        end
        if (wr_hit_s) begin
          shadow_nx_s  = wr_div;
          pending_nx_s = 1'b1;
        end else begin
          pending_nx_s = 1'b0;
        end
      end else if (!running_s) begin
        // Stopped: no boundary to wait for, a pending value applies next edge.
        cnt_nx_s     = DIV_ZERO;
        clk_out_nx_s = 1'b0;
        if (wr_hit_s) begin
          shadow_nx_s  = wr_div;
          pending_nx_s = 1'b1;
        end else if (pending_r) begin
          active_nx_s  = shadow_r;
          pending_nx_s = 1'b0;
        end else begin
          pending_nx_s = 1'b0;
        end
      end else if (boundary_s) begin
        // A write landing on the boundary bypasses the shadow.
        cnt_nx_s = DIV_ZERO;
        if (wr_hit_s) begin
          next_div_s  = wr_div;
          shadow_nx_s = wr_div;
        end else if (pending_r) begin
          next_div_s  = shadow_r;
          shadow_nx_s = shadow_r;
        end else begin
          next_div_s  = active_r;
          shadow_nx_s = shadow_r;
        end
        active_nx_s  = next_div_s;
        pending_nx_s = 1'b0;
        if (next_div_s == DIV_ZERO) begin
          clk_out_nx_s = 1'b0;
          tick_nx_s    = 1'b0;
        end else begin
          clk_out_nx_s = ~clk_out_r;
          tick_nx_s    = ~clk_out_r;
        end
      end else begin
        cnt_nx_s = cnt_r + DIV_ONE;
        if (wr_hit_s) begin
          shadow_nx_s  = wr_div;
          pending_nx_s = 1'b1;
        end else begin
          shadow_nx_s  = shadow_r;
          pending_nx_s = pending_r;
        end
      end
    end

    // Channel state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r     <= DIV_ZERO;
        active_r  <= DIV_RST_V;
        shadow_r  <= DIV_RST_V;
        pending_r <= 1'b0;
        clk_out_r <= 1'b0;
        tick_r    <= 1'b0;
      end else begin
        cnt_r     <= cnt_nx_s;
        active_r  <= active_nx_s;
        shadow_r  <= shadow_nx_s;
        pending_r <= pending_nx_s;
        clk_out_r <= clk_out_nx_s;
        tick_r    <= tick_nx_s;
      end
    end

    assign clk_out[i] = clk_out_r;
    assign tick[i]    = tick_r;
    assign pending[i] = pending_r;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_multi
//   Scoreboard bench for clock_divider_multi. The stimulus process drives
//   inputs on the falling edge, advances a countdown-based reference model
//   and queues the outputs expected after the next rising edge. A monitor
//   pops and compares one entry per rising edge.
// -----------------------------------------------------------------------------
module tb_clock_divider_multi;

  localparam int NUM_CH    = 5;
  localparam int DIV_W     = 8;
  localparam int DIV_RESET = 1;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              wr_en  = 1'b0;
  logic [CH_W-1:0]   wr_ch  = '0;
  logic [DIV_W-1:0]  wr_div = '0;
  logic              sync   = 1'b0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  typedef struct packed {
    logic [NUM_CH-1:0] co;
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] pd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: half-period, shadow, pending flag, level, and the
  // number of edges left until the current half-period ends.
  int m_div  [NUM_CH];
  int m_shad [NUM_CH];
  int m_rem  [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_lvl  [NUM_CH];
  bit m_tick [NUM_CH];

  clock_divider_multi #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .DIV_RESET(DIV_RESET)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .sync   (sync),
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [NUM_CH-1:0] got,
                       input logic [NUM_CH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]  = DIV_RESET;
      m_shad[i] = DIV_RESET;
      m_rem[i]  = DIV_RESET;
      m_pend[i] = 1'b0;
      m_lvl[i]  = 1'b0;
      m_tick[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit we, input int ch, input int dv, input bit sy);
    for (int i = 0; i < NUM_CH; i++) begin
      bit hit;
      int nd;
      hit       = we && (ch == i);
      m_tick[i] = 1'b0;
      if (sy && m_div[i] != 0) begin
        if (m_pend[i]) m_div[i] = m_shad[i];
        m_rem[i]  = m_div[i];
        m_lvl[i]  = 1'b0;
        m_pend[i] = hit;
        if (hit) m_shad[i] = dv;
      end else if (m_div[i] == 0) begin
        m_lvl[i] = 1'b0;
        if (hit) begin
          m_shad[i] = dv;
          m_pend[i] = 1'b1;
        end else if (m_pend[i]) begin
          m_div[i]  = m_shad[i];
          m_rem[i]  = m_div[i];
          m_pend[i] = 1'b0;
        end
      end else if (m_rem[i] == 1) begin
        nd = hit ? dv : (m_pend[i] ? m_shad[i] : m_div[i]);
        if (hit) m_shad[i] = dv;
        m_pend[i] = 1'b0;
        m_div[i]  = nd;
        m_rem[i]  = nd;
        if (nd == 0) begin
          m_lvl[i] = 1'b0;
        end else begin
          m_lvl[i]  = !m_lvl[i];
          m_tick[i] = m_lvl[i];
        end
      end else begin
        m_rem[i] = m_rem[i] - 1;
        if (hit) begin
          m_shad[i] = dv;
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      e.co[i] = m_lvl[i];
      e.tk[i] = m_tick[i];
      e.pd[i] = m_pend[i];
    end
    return e;
  endfunction

  task automatic drive(input bit rn, input bit we, input int ch, input int dv, input bit sy);
    bit sy_eff;
    @(negedge clk);
    cyc++;
    rst_n  = rn;
    wr_en  = we;
    wr_ch  = CH_W'(ch);
    wr_div = DIV_W'(dv);
    sync   = sy;
`ifdef CLKDIV_PHASE_SYNC_EN
    sy_eff = sy;
`else
    sy_eff = 1'b0;
`endif
    if (!rn) model_reset();
    else     model_edge(we, ch, dv, sy_eff);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int ch, input int dv);
    drive(1'b1, 1'b1, ch, dv, 1'b0);
  endtask

  // Monitor: one expected entry per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("clk_out", clk_out, e.co);
        check("tick",    tick,    e.tk);
        check("pending", pending, e.pd);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int dv;
    model_reset();
    exp_q.push_back(model_out());
    repeat (3) drive(1'b0, 1'b0, 0, 0, 1'b0);

    idle(8);                                 // all channels at clk/2
    wr(1, 2); idle(5); wr(1, 3); idle(20);   // mid-period write on ch1
    wr(2, 0); idle(4); wr(2, 5); idle(25);   // stop then restart ch2
    wr(3, 4); idle(2); wr(3, 6); wr(3, 7); idle(32);
    wr(NUM_CH, 9); idle(3); wr(7, 0); idle(3);
    wr(0, 3); idle(4);                       // ch0 write
    wr(4, 1); idle(2);
    wr(0, 2); wr(1, 4); idle(7);
    drive(1'b1, 1'b0, 0, 0, 1'b1);           // phase-align strobe
    idle(12);

    // Asynchronous reset mid-period: outputs must clear at once.
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    #1;
    check("async_rst", {clk_out, tick, pending}, '0);
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    idle(6);

    for (int n = 0; n < 3000; n++) begin
      dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 20))
                                       : int'($urandom_range(0, 6));
      drive(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, (1 << CH_W) - 1)),
            dv,
            ($urandom_range(0, 39) == 0));
    end
    idle(2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d entries left expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
